// File: rtl/debounced_seq_detector_if.sv
// Button / sequence bus between the stimulus side (master) and debounced_seq_detector (slave).
interface debounced_seq_detector_if #(
  parameter int NUM_BTN = 2,
  parameter int SEQ_LEN = 4
);
  localparam int IDX_W = ($clog2(NUM_BTN) > 1) ? $clog2(NUM_BTN) : 1;
  localparam int PW    = $clog2(SEQ_LEN + 1);

  logic [NUM_BTN-1:0]       btn;
  logic [SEQ_LEN*IDX_W-1:0] seq_code;
  logic [NUM_BTN-1:0]       btn_db;
  logic [PW-1:0]            progress;
  logic                     z;
  logic                     err;
  logic                     timeout;

  modport master (output btn, seq_code, input btn_db, progress, z, err, timeout);
  modport slave  (input btn, seq_code, output btn_db, progress, z, err, timeout);
endinterface

// File: rtl/debounced_seq_detector.sv
// Debounced push-button sequence detector: per-channel sync/debounce lanes feeding a Moore matcher.
// Optional inactivity timeout is compiled in with `define SEQ_DET_TIMEOUT_EN.

module debounced_seq_detector_lane #(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2, db_q;
  logic [CW-1:0] cnt;

  // db flips once DB_CYCLES consecutive synchronised samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      rise <= db & ~db_q;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module debounced_seq_detector #(
  parameter int NUM_BTN        = 2,
  parameter int SEQ_LEN        = 4,
  parameter int DB_CYCLES      = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  debounced_seq_detector_if.slave  bus
);
  localparam int IDX_W = ($clog2(NUM_BTN) > 1) ? $clog2(NUM_BTN) : 1;
  localparam int PW    = $clog2(SEQ_LEN + 1);

  typedef enum logic [1:0] {IDLE, STEP, MATCH} state_t;

  state_t             state;
  logic [PW-1:0]      progress;
  logic               z_r, err_r;
  logic [NUM_BTN-1:0] btn_db, rise;
  logic               multi, single, tmo_hit;
  logic [IDX_W-1:0]   sym, sym0, sym_exp;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    debounced_seq_detector_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (bus.btn[i]),
      .db      (btn_db[i]),
      .rise    (rise[i])
    );
  end

  assign multi  = $countones(rise) > 1;
  assign single = $countones(rise) == 1;
  assign sym0   = bus.seq_code[IDX_W-1:0];

  always_comb begin
    sym = '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (rise[i]) sym = IDX_W'(i);
  end

  // Expected symbol is looked up live so a seq_code change only affects later presses.
  always_comb begin
    sym_exp = sym0;
    for (int k = 0; k < SEQ_LEN; k++)
      if (progress == PW'(k)) sym_exp = bus.seq_code[k*IDX_W +: IDX_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      progress <= '0;
      z_r      <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      z_r   <= 1'b0;
      err_r <= 1'b0;
      if (multi) begin
        state    <= IDLE;
        progress <= '0;
        err_r    <= 1'b1;
      end else if (single) begin
        case (state)
          STEP: begin
            if (sym == sym_exp) begin
              if (progress == PW'(SEQ_LEN - 1)) begin
                state <= MATCH;
                z_r   <= 1'b1;
              end
              progress <= progress + 1'b1;
            end else if (sym == sym0) begin
              progress <= PW'(1);
              err_r    <= 1'b1;
            end else begin
              state    <= IDLE;
              progress <= '0;
              err_r    <= 1'b1;
            end
          end
          // IDLE and the single MATCH cycle both restart only on symbol 0, silently otherwise.
          default: begin
            if (sym == sym0) begin
              state    <= STEP;
              progress <= PW'(1);
            end else begin
              state    <= IDLE;
              progress <= '0;
            end
          end
        endcase
      end else if (state == MATCH || tmo_hit) begin
        state    <= IDLE;
        progress <= '0;
      end
    end
  end

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          timeout_r;

  assign tmo_hit = (state == STEP) && !(|rise) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= tmo_hit;
      if ((|rise) || state != STEP || tmo_hit) idle_cnt <= '0;
      else                                     idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign bus.timeout = timeout_r;
`else
  assign tmo_hit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.btn_db   = btn_db;
  assign bus.progress = progress;
  assign bus.z        = z_r;
  assign bus.err      = err_r;
endmodule
